// File: rtl/port_uart_pkg.sv
// port_uart_pkg: shared encodings for port_uart_tx.
// Optional feature macro: PORT_UART_TX_PARITY_EN (adds the PARITY state).
package port_uart_pkg;

  // FSM state encodings
  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_START  = 3'd1;
  localparam logic [2:0] ENC_DATA   = 3'd2;
`ifdef PORT_UART_TX_PARITY_EN
  localparam logic [2:0] ENC_PARITY = 3'd3;
`endif
  localparam logic [2:0] ENC_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ENC_IDLE,
    S_START  = ENC_START,
    S_DATA   = ENC_DATA,
`ifdef PORT_UART_TX_PARITY_EN
    S_PARITY = ENC_PARITY,
`endif
    S_STOP   = ENC_STOP
  } uart_state_e;

  // Bit positions inside the status word returned to the CPU
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_ACT   = 3;
  localparam int ST_ACK   = 8;
  localparam int ST_LVL   = 16;

endpackage

// File: rtl/port_uart_tx_fifo.sv
// sync_fifo_8: byte-wide synchronous FIFO, depth 2**FIFO_AW, with fill level.
// Pointers wrap modulo depth; the level saturates at depth because a push
// is only honoured while not full or when a pop frees a slot the same clk.
module sync_fifo_8 #(
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       wdata,
  input  logic             pop,
  output logic [7:0]       rdata,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] level
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  // Storage array written on accepted pushes.
  // NOTE: the data array has no reset; only pointers and level define validity, so resetting it would just cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and fill-level bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/port_uart_tx.sv
// port_uart_tx: queues bytes written through the CPU port_out bus and sends
// them 8N1, LSB first, on tx; returns a registered status word for port_in.
// Optional feature macro: PORT_UART_TX_PARITY_EN inserts an even-parity bit.
module port_uart_tx
  import port_uart_pkg::*;
#(
  parameter int WIDTH_REG    = 32,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_AW      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH_REG-1:0] port_out,
  output logic [WIDTH_REG-1:0] status,
  output logic                 tx
);

  localparam logic [15:0]          BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [WIDTH_REG-1:0] STATUS_RST = WIDTH_REG'(1) << ST_EMPTY;

  logic             tog_q, clr_q, ack_q, ovf_q;
  logic             push_req, clr_req, push_ok, drop, pop;
  logic             fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_level;
  logic [7:0]       fifo_rdata;

  uart_state_e      state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d, bit_done;
`ifdef PORT_UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif
  logic [WIDTH_REG-1:0] status_d;
  logic             unused_hi;

  // A write is signalled by flipping a toggle bit rather than by a strobe.
  assign push_req  = (port_out[8] != tog_q);
  assign clr_req   = (port_out[9] != clr_q);
  assign push_ok   = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;
  assign bit_done  = (cnt_q == '0);
  assign unused_hi = ^port_out[WIDTH_REG-1:10];

  sync_fifo_8 #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .wdata (port_out[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Toggle shadows, write acknowledge and sticky overflow (drop beats clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tog_q <= 1'b0;
      clr_q <= 1'b0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      tog_q <= port_out[8];
      clr_q <= port_out[9];
      if (push_req) ack_q <= port_out[8];
      if (drop)         ovf_q <= 1'b1;
      else if (clr_req) ovf_q <= 1'b0;
    end
  end

  // Serialiser state, baud counter, shifter and registered tx pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
`ifdef PORT_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
`ifdef PORT_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state, bit timing and pin value; tx is registered so it trails the state by one clk.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
`ifdef PORT_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          cnt_d   = BIT_RELOAD;
          bit_d   = '0;
          state_d = S_START;
`ifdef PORT_UART_TX_PARITY_EN
          par_d   = ^fifo_rdata;
`endif
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          cnt_d   = BIT_RELOAD;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          cnt_d   = BIT_RELOAD;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef PORT_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef PORT_UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = par_q;
        if (bit_done) begin
          cnt_d   = BIT_RELOAD;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          cnt_d   = BIT_RELOAD;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status word assembled from current internal state.
  always_comb begin
    status_d                        = '0;
    status_d[ST_FULL]               = fifo_full;
    status_d[ST_EMPTY]              = fifo_empty;
    status_d[ST_OVF]                = ovf_q;
    status_d[ST_ACT]                = (state_q != S_IDLE);
    status_d[ST_ACK]                = ack_q;
    status_d[ST_LVL +: FIFO_AW + 1] = fifo_level;
  end

  // Status register, one clk behind the internal state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) status <= STATUS_RST;
    else       status <= status_d;
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: directed self-checking bench for port_uart_tx
// (CLKS_PER_BIT=4, FIFO_AW=2). Build with PORT_UART_TX_PARITY_EN for the parity variant.
module tb_port_uart_tx;

  localparam int CPB = 4;
  localparam int AW  = 2;
  localparam int W   = 32;
`ifdef PORT_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = CPB * NBITS;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] port_out;
  logic [W-1:0] status;
  logic         tx;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic tog      = 1'b0;
  logic clr      = 1'b0;
  bit   mon_en   = 1'b0;
  logic [7:0] rx_q[$];
  logic       rx_stop_q[$];

  always #5 clk = ~clk;

  port_uart_tx #(.WIDTH_REG(W), .CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .port_out (port_out),
    .status   (status),
    .tx       (tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected line level for bit slot k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef PORT_UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status(input logic full, input logic empty, input logic ovf,
                                             input logic act, input logic ack, input int lvl);
    logic [31:0] s;
    s         = '0;
    s[0]      = full;
    s[1]      = empty;
    s[2]      = ovf;
    s[3]      = act;
    s[8]      = ack;
    s[16 +: 3] = 3'(lvl);
    return s;
  endfunction

  task automatic write_byte(input logic [7:0] b, input bit clr_too);
    tog           = ~tog;
    port_out[7:0] = b;
    port_out[8]   = tog;
    if (clr_too) begin
      clr         = ~clr;
      port_out[9] = clr;
    end
  endtask

  task automatic clear_ovf;
    clr         = ~clr;
    port_out[9] = clr;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int i = 0;
    while (rx_q.size() < n && i < budget) begin
      tick;
      i++;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic check_rx(input logic [7:0] base, input int n, input string tag);
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], base + 8'(i));
      check($sformatf("%s_stop%0d", tag, i), rx_stop_q[i], 1);
    end
  endtask

  // Single write into an idle, empty block: latency, ack, cycle-exact waveform.
  task automatic send_and_check(input logic [7:0] b, input string tag);
    int bad = 0;
    write_byte(b, 1'b0);
    tick;
    check({tag, "_lat0"}, tx, 1);
    tick;
    check({tag, "_lat1"}, tx, 1);
    check({tag, "_ack"}, status[8], tog);
    tick;
    for (int k = 0; k < FRAME; k++) begin
      if (tx !== frame_bit(b, k / CPB)) bad++;
      if (k == CPB) check({tag, "_busy"}, status, exp_status(0, 1, 0, 1, tog, 0));
      tick;
    end
    check({tag, "_wave"}, bad, 0);
    check({tag, "_end_tx"}, tx, 1);
    check({tag, "_end_status"}, status, exp_status(0, 1, 0, 0, tog, 0));
  endtask

  // Independent UART receiver sampling at bit centres on the falling clock edge.
  always begin : uart_mon
    logic [7:0] b;
    logic       stop;
    @(negedge clk);
    if (mon_en && reset === 1'b0 && tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge clk);
        b[j] = tx;
      end
`ifdef PORT_UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
`endif
      repeat (CPB) @(negedge clk);
      stop = tx;
      rx_q.push_back(b);
      rx_stop_q.push_back(stop);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    port_out = '0;
    repeat (3) tick;
    check("rst_tx", tx, 1);
    check("rst_status", status, 32'h0000_0002);
    reset = 1'b0;
    tick;
    check("post_rst_status", status, 32'h0000_0002);
    check("post_rst_tx", tx, 1);

    // Reset in the middle of a frame of zeros
    write_byte(8'h00, 1'b0);
    repeat (12) tick;
    check("t1_tx_low", tx, 0);
    reset    = 1'b1;
    port_out = '0;
    tog      = 1'b0;
    clr      = 1'b0;
    #1;
    check("t1_tx_async", tx, 1);
    check("t1_status_async", status, 32'h0000_0002);
    tick;
    tick;
    reset = 1'b0;
    repeat (20) tick;
    check("t1_tx_idle", tx, 1);
    check("t1_status", status, 32'h0000_0002);

    mon_en = 1'b1;

    // Single frames, cycle-exact
    send_and_check(8'h55, "t2");
    send_and_check(8'h07, "t6a");
    send_and_check(8'h03, "t6b");
    check("t2_rx_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("t2_rx0", rx_q[0], 8'h55);
      check("t2_rx1", rx_q[1], 8'h07);
      check("t2_rx2", rx_q[2], 8'h03);
    end
    rx_q.delete();
    rx_stop_q.delete();

    // Six back-to-back writes: one in flight, four queued, one dropped
    for (int i = 0; i < 6; i++) begin
      write_byte(8'hA0 + 8'(i), 1'b0);
      tick;
    end
    tick;
    check("t3_status_full", status, exp_status(1, 0, 1, 1, tog, 4));
    wait_rx(5, 5 * (FRAME + 2) + 20, "t3_rx_count");
    check_rx(8'hA0, 5, "t3");
    repeat (60) tick;
    check("t3_no_sixth", rx_q.size(), 5);
    check("t3_status_drained", status, exp_status(0, 1, 1, 0, tog, 0));

    // Overflow clear, then clear and drop on the same clk
    clear_ovf;
    tick;
    check("t4_ovf_lag", status, exp_status(0, 1, 1, 0, tog, 0));
    tick;
    check("t4_ovf_clr", status, exp_status(0, 1, 0, 0, tog, 0));
    rx_q.delete();
    rx_stop_q.delete();
    for (int i = 0; i < 6; i++) begin
      write_byte(8'hB0 + 8'(i), i == 5);
      tick;
    end
    tick;
    check("t4_drop_wins", status, exp_status(1, 0, 1, 1, tog, 4));
    wait_rx(5, 5 * (FRAME + 2) + 20, "t4_rx_count");
    check_rx(8'hB0, 5, "t4");
    repeat (60) tick;
    check("t4_no_sixth", rx_q.size(), 5);

    // Write while full on the clk the serialiser pops the next byte
    clear_ovf;
    tick;
    tick;
    check("t5_start", status, exp_status(0, 1, 0, 0, tog, 0));
    rx_q.delete();
    rx_stop_q.delete();
    for (int i = 0; i < 5; i++) begin
      write_byte(8'hC0 + 8'(i), 1'b0);
      tick;
    end
    repeat (FRAME - 3) tick;
    check("t5_pre_full", status, exp_status(1, 0, 0, 1, tog, 4));
    write_byte(8'hC5, 1'b0);
    tick;
    tick;
    check("t5_accept", status, exp_status(1, 0, 0, 1, tog, 4));
    wait_rx(6, 6 * (FRAME + 2) + 20, "t5_rx_count");
    check_rx(8'hC0, 6, "t5");
    repeat (20) tick;
    check("t5_final_status", status, exp_status(0, 1, 0, 0, tog, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
